// File: rtl/mem_bus_master_if.sv
// Request/response handshake bundle for mem_bus_master; no state, zero latency.
// Backpressure: req_ready from the slave gates request transfer; the response path has none.
interface mem_bus_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [1:0] req_addr;
    logic [3:0] req_wdata;
    logic       rsp_valid;
    logic [3:0] rsp_rdata;
    logic       busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/mem_bus_master.sv
// Queues requests and sequences them onto a shared-bus memory. Pop 1 cycle after push; write 1 cycle, read RD_WAIT+1.
// Backpressure: req_ready drops while the request FIFO is full; read responses are unthrottled 1-cycle pulses.
module mem_bus_master #(
    parameter int FIFO_DEPTH = 2,
    parameter int RD_WAIT    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_bus_master_if.slave  bus,
    output logic [1:0]       mem_addr,
    output logic             mem_rwb,
    inout  wire  [3:0]       dbus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int WW = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;

    typedef struct packed {
        logic       we;
        logic [1:0] addr;
        logic [3:0] wdata;
    } req_t;

    req_t          fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [WW-1:0] wait_cnt;
    logic          drive_en;
    logic [3:0]    wdata_q;
    logic          rsp_valid_q;
    logic [3:0]    rsp_rdata_q;

    req_t head;
    logic push;
    logic pop;
    logic rd_last;
    logic op_done;

    assign head    = fifo_mem[rd_ptr];
    assign rd_last = (state == S_RD) && (wait_cnt == '0);
    assign op_done = (state == S_WR) || rd_last;
    assign push    = bus.req_valid && bus.req_ready;
    // Pop on the edge that finishes the current op, so ops run back to back.
    assign pop     = ((state == S_IDLE) || op_done) && (count != '0);

    assign bus.req_ready = (count != CW'(FIFO_DEPTH));
    assign bus.busy      = (count != '0) || (state != S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    assign dbus = drive_en ? wdata_q : 4'bzzzz;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            state       <= S_IDLE;
            wait_cnt    <= '0;
            drive_en    <= 1'b0;
            wdata_q     <= '0;
            mem_addr    <= '0;
            mem_rwb     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);

            rsp_valid_q <= 1'b0;
            if (rd_last) begin
                rsp_rdata_q <= dbus;
                rsp_valid_q <= 1'b1;
            end else if (state == S_RD) begin
                wait_cnt <= wait_cnt - WW'(1);
            end

            if (pop) begin
                mem_addr <= head.addr;
                if (head.we) begin
                    state    <= S_WR;
                    mem_rwb  <= 1'b0;
                    drive_en <= 1'b1;
                    wdata_q  <= head.wdata;
                end else begin
                    state    <= S_RD;
                    mem_rwb  <= 1'b1;
                    drive_en <= 1'b0;
                    wait_cnt <= WW'(RD_WAIT);
                end
            end else if (op_done) begin
                state    <= S_IDLE;
                mem_rwb  <= 1'b1;
                drive_en <= 1'b0;
            end
        end
    end
endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Bus-master stage directly upstream of the 4-word x 4-bit shared-bus memory.
- Accepts read/write requests over a valid/ready handshake and buffers them in a small request FIFO.
- Sequences each request onto the memory's address / rwb / bidirectional data bus, and returns read data on a one-cycle response strobe.
- Owns tri-state drive of the data bus: drives it only while writing, high-Z otherwise.

Parameters:
- FIFO_DEPTH, 2, request FIFO entries (power of 2, >= 2).
- RD_WAIT, 1, extra settle cycles between presenting a read address and sampling dbus (>= 0).

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  FIFO can accept; high when FIFO not full.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  2  memory word address.
- req_wdata  input  4  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse: rsp_rdata holds new read data.
- rsp_rdata  output  4  last read data; held until the next response.
- busy  output  1  FIFO non-empty or FSM not IDLE.
- mem_addr  output  2  memory address, registered.
- mem_rwb  output  1  memory mode: 1 = read, 0 = write; registered.
- dbus  inout  4  memory data bus; driven with the write-data register when drive_en = 1, else 4'bzzzz.

Behaviour:
- Reset (rst_n low, takes effect asynchronously):
  - FSM = IDLE; FIFO emptied; pending requests dropped.
  - mem_rwb = 1 and mem_addr = 00, so the memory stays non-destructive.
  - drive_en = 0, so dbus = Z immediately.
  - rsp_valid = 0, rsp_rdata = 0000, busy = 0, req_ready = 1.
- Handshake:
  - Push when req_valid && req_ready at posedge; {we, addr, wdata} enters the FIFO tail.
  - req_ready = !full, combinational from FIFO count.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - When full, req_ready = 0 and req_valid is ignored.
- FSM states: IDLE, WR, RD.
  - Pop rule: at any posedge where the state is IDLE, or the current op completes this edge, and the FIFO is non-empty:
    - pop the head;
    - load mem_addr;
    - enter WR (mem_rwb = 0, drive_en = 1, wdata register = head wdata) or RD (mem_rwb = 1, drive_en = 0, wait counter = RD_WAIT).
  - WR: lasts exactly 1 cycle. The memory latches dbus at the edge that ends WR. Then pop the next request or go to IDLE.
  - RD: lasts RD_WAIT+1 cycles. At the final edge:
    - sample dbus into rsp_rdata;
    - rsp_valid = 1 for the following cycle only;
    - pop the next request or go to IDLE.
  - IDLE: mem_rwb = 1, drive_en = 0; mem_addr holds its last value.
- Latency:
  - Request pushed at edge E0 while IDLE: popped at E1.
  - Write lands in memory at E2.
  - Read data sampled at E2+RD_WAIT; rsp_valid is high in the cycle after that edge.
- Throughput:
  - Back-to-back writes: 1 per cycle.
  - Reads: 1 per RD_WAIT+1 cycles.
  - No idle bubble between ops while the FIFO is non-empty.
- Ordering: strict FIFO order, so a read after a write to the same address returns the new data.
- No backpressure on the response path; the consumer must take rsp_valid when it pulses.
- dbus contention: drive_en is registered and asserted only in WR. mem_rwb = 0 exactly in WR, so the memory's write window matches master drive.
- Reset mid-operation: an in-flight WR is abandoned; whether the memory captured it depends on edge timing. The bench must not check that word. dbus releases within the reset assertion.
- Width rules: the FIFO count is log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Write/read-back: push writes (00,0000), (01,0101), (10,1010), (11,1111), then reads 00..11 -> rsp_rdata sequence 0000, 0101, 1010, 1111, each with a single-cycle rsp_valid.
- Throughput: 4 writes pushed on consecutive cycles -> mem_rwb = 0 for 4 consecutive cycles; mem_addr 00,01,10,11; dbus driven only in those cycles, Z before and after.
- Back-pressure: hold the FSM busy with a read at RD_WAIT=3 and push 3 more requests -> req_ready falls after 2 are queued (FIFO_DEPTH=2); the third is accepted the cycle after a pop; no request lost or duplicated.
- RAW ordering: write (10,0110) immediately followed by read 10 -> rsp_rdata = 0110.
- Reset mid-stream: assert rst_n low during a WR with 2 queued -> dbus = Z, mem_rwb = 1, busy = 0, rsp_valid = 0 asynchronously; after release, no queued op executes.
- Idle: no requests for 10 cycles after reset -> busy = 0, mem_rwb = 1, dbus = Z, rsp_valid never pulses.
